// File: rtl/render_sequencer.sv
// Frame sequencer: runs clear -> walls -> crosshair render stages once per frame tick
// and muxes the active stage's pixel stream onto the VGA adapter. Optional stage
// watchdog is enabled with `define RENDER_TIMEOUT_EN.
module render_sequencer #(
  parameter logic [7:0]  CROSS_X = 8'd80,
  parameter logic [6:0]  CROSS_Y = 7'd60,
  parameter logic [15:0] TIMEOUT = 16'd40000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  output logic        clear_start,
  input  logic        clear_done,
  output logic        walls_start,
  input  logic        walls_done,
  output logic        xhair_start,
  input  logic        xhair_done,
  input  logic [7:0]  clear_x,
  input  logic [6:0]  clear_y,
  input  logic [17:0] clear_colour,
  input  logic        clear_write,
  input  logic [7:0]  walls_x,
  input  logic [6:0]  walls_y,
  input  logic [17:0] walls_colour,
  input  logic        walls_write,
  input  logic [7:0]  xhair_x,
  input  logic [6:0]  xhair_y,
  input  logic [17:0] xhair_colour,
  input  logic        xhair_write,
  output logic [7:0]  center_x,
  output logic [6:0]  center_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [17:0] vga_colour,
  output logic        vga_write,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count
`ifdef RENDER_TIMEOUT_EN
  ,
  output logic        timeout_flag
`endif
);

  typedef enum logic [2:0] {
    IDLE, START_CLEAR, WAIT_CLEAR, START_WALLS,
    WAIT_WALLS, START_XHAIR, WAIT_XHAIR, FRAME_DONE
  } state_t;

  state_t state, state_next;
  logic   pending;
  logic   leave_idle;
  logic   stage_done;
  logic   stage_timeout;

  assign center_x   = CROSS_X;
  assign center_y   = CROSS_Y;
  assign busy       = (state != IDLE);
  assign leave_idle = (state == IDLE) && enable && (frame_tick || pending);

  // Done of the stage currently being waited on; other stages' done is ignored.
  always_comb begin
    stage_done = 1'b0;
    case (state)
      WAIT_CLEAR: stage_done = clear_done;
      WAIT_WALLS: stage_done = walls_done;
      WAIT_XHAIR: stage_done = xhair_done;
      default:    stage_done = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_next  = state;
    clear_start = 1'b0;
    walls_start = 1'b0;
    xhair_start = 1'b0;
    vga_x       = '0;
    vga_y       = '0;
    vga_colour  = '0;
    vga_write   = 1'b0;
    case (state)
      IDLE: if (leave_idle) state_next = START_CLEAR;
      START_CLEAR: begin
        clear_start = 1'b1;
        state_next  = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        vga_x      = clear_x;
        vga_y      = clear_y;
        vga_colour = clear_colour;
        vga_write  = clear_write;
        if (stage_done || stage_timeout) state_next = START_WALLS;
      end
      START_WALLS: begin
        walls_start = 1'b1;
        state_next  = WAIT_WALLS;
      end
      WAIT_WALLS: begin
        vga_x      = walls_x;
        vga_y      = walls_y;
        vga_colour = walls_colour;
        vga_write  = walls_write;
        if (stage_done || stage_timeout) state_next = START_XHAIR;
      end
      START_XHAIR: begin
        xhair_start = 1'b1;
        state_next  = WAIT_XHAIR;
      end
      WAIT_XHAIR: begin
        vga_x      = xhair_x;
        vga_y      = xhair_y;
        vga_colour = xhair_colour;
        vga_write  = xhair_write;
        if (stage_done || stage_timeout) state_next = FRAME_DONE;
      end
      FRAME_DONE: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      state <= state_next;
      // Starting a frame consumes the pending request, including a tick in that cycle.
      if (leave_idle)
        pending <= 1'b0;
      else if (frame_tick)
        pending <= 1'b1;
      if (frame_tick && busy && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 8'd1;
      if (state == FRAME_DONE)
        frame_count <= frame_count + 16'd1;
    end
  end

`ifdef RENDER_TIMEOUT_EN
  logic [15:0] wd_count;
  logic        in_wait;

  assign in_wait       = (state == WAIT_CLEAR) || (state == WAIT_WALLS) || (state == WAIT_XHAIR);
  // The n-th cycle of a WAIT state sees wd_count = n-1, so the stage gets TIMEOUT cycles.
  assign stage_timeout = in_wait && (({1'b0, wd_count} + 17'd1) >= {1'b0, TIMEOUT});

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_count     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (!in_wait)
        wd_count <= '0;
      else if (wd_count != 16'hFFFF)
        wd_count <= wd_count + 16'd1;
      if (stage_timeout && !stage_done)
        timeout_flag <= 1'b1;
    end
  end
`else
  assign stage_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_render_sequencer.sv
// Directed self-checking bench for render_sequencer: frame timing, VGA mux, overrun
// handling, enable gating, mid-frame reset and (with RENDER_TIMEOUT_EN) the watchdog.
module tb_render_sequencer;

  logic        clock;
  logic        reset;
  logic        frame_tick;
  logic        enable;
  logic        clear_start, walls_start, xhair_start;
  logic        clear_done, walls_done, xhair_done;
  logic [7:0]  clear_x, walls_x, xhair_x;
  logic [6:0]  clear_y, walls_y, xhair_y;
  logic [17:0] clear_colour, walls_colour, xhair_colour;
  logic        clear_write, walls_write, xhair_write;
  logic [7:0]  center_x;
  logic [6:0]  center_y;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour;
  logic        vga_write;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
`ifdef RENDER_TIMEOUT_EN
  logic        timeout_flag;
`endif

  // Stage models: automatic responders (done 4 cycles after start) or manual pulses.
  logic [2:0] auto_en;
  logic [2:0] m_done;
  logic [2:0] a_done;
  logic [2:0] starts;
  int         cnt [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign starts     = {xhair_start, walls_start, clear_start};
  assign clear_done = auto_en[0] ? a_done[0] : m_done[0];
  assign walls_done = auto_en[1] ? a_done[1] : m_done[1];
  assign xhair_done = auto_en[2] ? a_done[2] : m_done[2];

  render_sequencer #(.TIMEOUT(16'd10)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .clear_start(clear_start), .clear_done(clear_done),
    .walls_start(walls_start), .walls_done(walls_done),
    .xhair_start(xhair_start), .xhair_done(xhair_done),
    .clear_x(clear_x), .clear_y(clear_y), .clear_colour(clear_colour), .clear_write(clear_write),
    .walls_x(walls_x), .walls_y(walls_y), .walls_colour(walls_colour), .walls_write(walls_write),
    .xhair_x(xhair_x), .xhair_y(xhair_y), .xhair_colour(xhair_colour), .xhair_write(xhair_write),
    .center_x(center_x), .center_y(center_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write),
    .busy(busy), .frame_count(frame_count), .overrun_count(overrun_count)
`ifdef RENDER_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    for (int s = 0; s < 3; s++) begin
      if (!reset) begin
        cnt[s] = 0;
        a_done[s] = 1'b0;
      end else if (starts[s]) begin
        cnt[s] = 4;
        a_done[s] = 1'b0;
      end else if (cnt[s] != 0) begin
        cnt[s] = cnt[s] - 1;
        a_done[s] = (cnt[s] == 0);
      end else begin
        a_done[s] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    frame_tick = 1'b0;
    next();
    next();
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      next();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int n_st [3];
    int at_st [3];
    int second_at;

    reset = 1'b0; enable = 1'b0; frame_tick = 1'b0;
    auto_en = 3'b111; m_done = 3'b000;
    clear_x = 8'd7; clear_y = 7'd9; clear_colour = 18'h12345; clear_write = 1'b1;
    walls_x = '0; walls_y = '0; walls_colour = '0; walls_write = 1'b0;
    xhair_x = '0; xhair_y = '0; xhair_colour = '0; xhair_write = 1'b0;

    // Reset state, with a stage write pending that must not reach the adapter.
    repeat (3) next();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_starts", {29'd0, starts}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_overrun", {24'd0, overrun_count}, 32'd0);
    check("rst_vga_write", {31'd0, vga_write}, 32'd0);
    check("rst_vga_x", {24'd0, vga_x}, 32'd0);
    check("rst_vga_colour", {14'd0, vga_colour}, 32'd0);
    check("center_x", {24'd0, center_x}, 32'd80);
    check("center_y", {25'd0, center_y}, 32'd60);

    // Single frame timing: tick at cycle 5.
    reset = 1'b1; enable = 1'b1; clear_write = 1'b0; cyc = 0;
    for (int s = 0; s < 3; s++) begin n_st[s] = 0; at_st[s] = -1; end
    while (cyc < 24) begin
      frame_tick = (cyc == 5);
      next();
      for (int s = 0; s < 3; s++)
        if (starts[s]) begin n_st[s]++; at_st[s] = cyc; end
      if (cyc == 21) begin
        check("f1_busy_c21", {31'd0, busy}, 32'd1);
        check("f1_count_c21", {16'd0, frame_count}, 32'd0);
      end
      if (cyc == 22) begin
        check("f1_busy_c22", {31'd0, busy}, 32'd0);
        check("f1_count_c22", {16'd0, frame_count}, 32'd1);
      end
    end
    check("f1_clear_at", at_st[0], 32'd6);
    check("f1_walls_at", at_st[1], 32'd11);
    check("f1_xhair_at", at_st[2], 32'd16);
    check("f1_clear_n", n_st[0], 32'd1);
    check("f1_walls_n", n_st[1], 32'd1);
    check("f1_xhair_n", n_st[2], 32'd1);

    // VGA mux and done filtering, with hand-paced stages.
    auto_en = 3'b000;
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
    check("mux_clear_start", {31'd0, clear_start}, 32'd1);
    next();
    clear_x = 8'd5;   clear_y = 7'd6;   clear_colour = 18'h3AAAA; clear_write = 1'b1;
    walls_x = 8'd100; walls_y = 7'd100; walls_colour = 18'h15555; walls_write = 1'b1;
    xhair_x = 8'd80;  xhair_y = 7'd59;  xhair_colour = 18'h2F0F0; xhair_write = 1'b1;
    #1;
    check("mux_clear_x", {24'd0, vga_x}, 32'd5);
    check("mux_clear_colour", {14'd0, vga_colour}, 32'h3AAAA);
    check("mux_clear_write", {31'd0, vga_write}, 32'd1);
    m_done = 3'b001;
    next();
    m_done = 3'b000;
    check("mux_walls_start", {31'd0, walls_start}, 32'd1);
    check("mux_start_write", {31'd0, vga_write}, 32'd0);
    next();
    check("mux_walls_x", {24'd0, vga_x}, 32'd100);
    check("mux_walls_y", {25'd0, vga_y}, 32'd100);
    m_done = 3'b101;
    next();
    m_done = 3'b000;
    check("ignore_done_state", {24'd0, vga_x}, 32'd100);
    check("ignore_done_xstart", {31'd0, xhair_start}, 32'd0);
    m_done = 3'b010;
    next();
    m_done = 3'b000;
    check("mux_xhair_start", {31'd0, xhair_start}, 32'd1);
    next();
    check("mux_xhair_write", {31'd0, vga_write}, 32'd1);
    check("mux_xhair_x", {24'd0, vga_x}, 32'd80);
    check("mux_xhair_y", {25'd0, vga_y}, 32'd59);
    check("mux_xhair_colour", {14'd0, vga_colour}, 32'h2F0F0);
    xhair_write = 1'b0;
    #1;
    check("mux_unselected_write", {31'd0, vga_write}, 32'd0);
    // Tick coinciding with done: both the advance and the overrun take effect.
    m_done = 3'b100;
    frame_tick = 1'b1;
    next();
    m_done = 3'b000;
    frame_tick = 1'b0;
    check("same_cycle_busy", {31'd0, busy}, 32'd1);
    check("same_cycle_overrun", {24'd0, overrun_count}, 32'd1);
    check("same_cycle_count", {16'd0, frame_count}, 32'd1);
    next();
    check("same_cycle_idle", {31'd0, busy}, 32'd0);
    check("same_cycle_count2", {16'd0, frame_count}, 32'd2);
    clear_write = 1'b0; walls_write = 1'b0;
    auto_en = 3'b111;
    next();
    check("pending_restart", {31'd0, clear_start}, 32'd1);
    wait_idle("pending_frame_idle", 60);
    check("pending_frame_count", {16'd0, frame_count}, 32'd3);

    // Three ticks in one frame: one extra frame only.
    do_reset();
    n_st[0] = 0; second_at = -1;
    frame_tick = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      next();
      frame_tick = (i == 2) || (i == 5) || (i == 8);
      if (clear_start) begin
        n_st[0]++;
        if (n_st[0] == 2) second_at = i;
      end
    end
    frame_tick = 1'b0;
    check("ovr_count", {24'd0, overrun_count}, 32'd3);
    check("ovr_frames_started", n_st[0], 32'd2);
    check("ovr_second_at", second_at, 32'd18);
    check("ovr_frame_count", {16'd0, frame_count}, 32'd2);
    check("ovr_idle", {31'd0, busy}, 32'd0);

    // Enable gating holds a pending frame in IDLE.
    enable = 1'b0;
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
    check("en_hold_busy", {31'd0, busy}, 32'd0);
    next();
    check("en_hold_start", {31'd0, clear_start}, 32'd0);
    enable = 1'b1;
    next();
    check("en_release_start", {31'd0, clear_start}, 32'd1);
    wait_idle("en_frame_idle", 60);
    check("en_overrun_kept", {24'd0, overrun_count}, 32'd3);
    check("en_frame_count", {16'd0, frame_count}, 32'd3);

    // Reset in WAIT_WALLS with a pending tick: frame abandoned, no restart.
    frame_tick = 1'b1;
    at_st[1] = -1;
    for (int i = 1; i <= 7; i++) begin
      next();
      frame_tick = (i == 3);
      if (walls_start) at_st[1] = i;
    end
    check("mid_walls_started", at_st[1], 32'd6);
    reset = 1'b0;
    next();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_count", {16'd0, frame_count}, 32'd0);
    check("mid_rst_overrun", {24'd0, overrun_count}, 32'd0);
    check("mid_rst_starts", {29'd0, starts}, 32'd0);
    reset = 1'b1;
    n_st[0] = 0;
    for (int i = 0; i < 25; i++) begin
      next();
      if (starts != 3'b000) n_st[0]++;
    end
    check("post_rst_no_starts", n_st[0], 32'd0);

    // Overrun saturation with the tick held high during a long stage.
    auto_en = 3'b000;
    frame_tick = 1'b1;
    repeat (300) next();
    frame_tick = 1'b0;
    check("ovr_saturate", {24'd0, overrun_count}, 32'd255);
`ifndef RENDER_TIMEOUT_EN
    check("wait_holds", {31'd0, busy}, 32'd1);
`endif
    do_reset();
    auto_en = 3'b111;

`ifdef RENDER_TIMEOUT_EN
    // Watchdog: walls never completes, so WAIT_WALLS lasts exactly 10 cycles.
    auto_en = 3'b101;
    frame_tick = 1'b1;
    at_st[1] = -1; at_st[2] = -1;
    for (int i = 1; i <= 17; i++) begin
      next();
      frame_tick = 1'b0;
      if (walls_start) at_st[1] = i;
      if (xhair_start && at_st[2] < 0) at_st[2] = i;
      if (i == 16) check("wd_flag_before", {31'd0, timeout_flag}, 32'd0);
    end
    check("wd_walls_at", at_st[1], 32'd6);
    check("wd_xhair_at", at_st[2], 32'd17);
    check("wd_flag_set", {31'd0, timeout_flag}, 32'd1);
    wait_idle("wd_frame_idle", 60);
    check("wd_flag_sticky", {31'd0, timeout_flag}, 32'd1);
    do_reset();
    check("wd_flag_reset", {31'd0, timeout_flag}, 32'd0);
    auto_en = 3'b111;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
